// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_SUM   = 2'd2;

  // States from which a new load request is honoured.
  function automatic logic accepts_start(state_e st);
    return (st == ST_IDLE) || (st == ST_RUN) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_sum_acc.sv
// Mod-2^DATA_W additive accumulator with synchronous clear and a compare output.
module imem_sum_acc #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [DATA_W-1:0] cmp_i,
  output logic              match_o
);

  logic [DATA_W-1:0] sum_q;

  // Running sum; clear wins over accumulate, overflow wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sum_q <= '0;
    else if (clr_i) sum_q <= '0;
    else if (en_i)  sum_q <= sum_q + din_i;
  end

  assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, streams host words into imem, checks the sum.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] exp_sum,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              init_mode,
  output logic              write_enable,
  output logic [ADDR_W-1:0] init_address,
  output logic [DATA_W-1:0] init_instruction,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  state_e state_q, state_d;

  // acc_q counts accepted beats and doubles as the next write address.
  logic [ADDR_W:0]   cnt_q, cnt_d, acc_q, acc_d;
  logic [DATA_W-1:0] exp_q, exp_d;

  logic              s_ready_q, s_ready_d;
  logic              init_mode_q, init_mode_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              core_reset_q, core_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_q, err_d;

  logic beat, take, start_ok, start_hit, sum_clr, sum_match;

  assign beat      = s_valid & s_ready_q;
  assign take      = beat & ~abort;
  assign start_ok  = (word_count != '0) && (word_count <= MAX_CNT);
  assign start_hit = start & ~abort & accepts_start(state_q);

  imem_sum_acc #(.DATA_W(DATA_W)) u_sum (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (sum_clr),
    .en_i    (take),
    .din_i   (s_data),
    .cmp_i   (exp_q),
    .match_o (sum_match)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything, start only from IDLE/RUN/ERROR.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN, ST_ERROR:
          if (start) state_d = start_ok ? ST_LOAD : ST_ERROR;
        // Leave LOAD only after the final beat's write strobe is on the bus.
        ST_LOAD:  if (we_q && (acc_q == cnt_q)) state_d = ST_CHECK;
        ST_CHECK: state_d = sum_match ? ST_RUN : ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Load bookkeeping: count/expected sum latched on a good start, beats counted.
  always_comb begin
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    acc_d   = acc_q;
    sum_clr = 1'b0;
    if (abort) begin
      acc_d   = '0;
      sum_clr = 1'b1;
    end else if (start_hit && start_ok) begin
      cnt_d   = word_count;
      exp_d   = exp_sum;
      acc_d   = '0;
      sum_clr = 1'b1;
    end else if (beat) begin
      acc_d = acc_q + 1'b1;
    end
  end

  // Output next-values, derived from the upcoming state so outputs line up with it.
  always_comb begin
    s_ready_d    = (state_d == ST_LOAD) && (acc_d < cnt_d);
    init_mode_d  = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    core_reset_d = (state_d != ST_RUN);
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_CHECK);
    done_d       = (state_d == ST_RUN);
    error_d      = (state_d == ST_ERROR);
    we_d         = take;
    addr_d       = take ? acc_q[ADDR_W-1:0] : addr_q;
    data_d       = take ? s_data : data_q;
    err_d        = err_q;
    if (abort)                                err_d = ERR_NONE;
    else if (start_hit)                       err_d = start_ok ? ERR_NONE : ERR_COUNT;
    else if (state_q == ST_CHECK && !sum_match) err_d = ERR_SUM;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      exp_q        <= '0;
      acc_q        <= '0;
      s_ready_q    <= 1'b0;
      init_mode_q  <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      acc_q        <= acc_d;
      s_ready_q    <= s_ready_d;
      init_mode_q  <= init_mode_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_q        <= err_d;
    end
  end

  assign s_ready          = s_ready_q;
  assign init_mode        = init_mode_q;
  assign write_enable     = we_q;
  assign init_address     = addr_q;
  assign init_instruction = data_q;
  assign core_reset       = core_reset_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign err_code         = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes queued per beat, popped per strobe.
module tb_imem_boot_loader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic [DATA_W-1:0] exp_sum = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              init_mode, write_enable, core_reset, busy, done, error;
  logic [ADDR_W-1:0] init_address;
  logic [DATA_W-1:0] init_instruction;
  logic [1:0]        err_code;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(4096)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .word_count(word_count), .exp_sum(exp_sum),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .init_mode(init_mode), .write_enable(write_enable),
    .init_address(init_address), .init_instruction(init_instruction),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               sb[$];
  logic [DATA_W-1:0] wq[$];
  int                n_chk = 0;
  int                n_fail = 0;
  int                nwr = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding beat.
  always @(negedge clk) begin
    if (reset && write_enable) begin
      wr_t e;
      nwr++;
      last_addr = init_address;
      if (sb.size() == 0) chk("unexp_wr", write_enable, 1'b0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", init_address, e.addr);
        chk("wr_data", init_instruction, e.data);
      end
    end
  end

  function automatic logic [DATA_W-1:0] qsum();
    logic [DATA_W-1:0] s = '0;
    foreach (wq[i]) s += wq[i];
    return s;
  endfunction

  task automatic fill(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  task automatic do_start(input int cnt, input logic [DATA_W-1:0] es);
    @(negedge clk);
    start = 1'b1; word_count = (ADDR_W+1)'(cnt); exp_sum = es;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer the first n words of wq; a beat is decided from s_ready before the edge.
  task automatic send(input int n, input bit stall);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 20000) begin
      if (cyc != 0) @(negedge clk);
      s_valid = stall ? (cyc % 2 == 0) : 1'b1;
      s_data  = wq[i];
      if (s_valid && s_ready) begin
        sb.push_back({ADDR_W'(i), wq[i]});
        i++;
      end
      cyc++;
    end
    chk("send_budget", i, n);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int c = 0;
    while (!(done || error) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("end_timeout", done | error, 1'b1);
  endtask

  task automatic good_load(input string tag, input int n, input bit stall);
    nwr = 0;
    fill(n);
    do_start(n, qsum());
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_mode"}, init_mode, 1'b1);
    chk({tag, "_rdy"}, s_ready, 1'b1);
    chk({tag, "_crst"}, core_reset, 1'b1);
    send(n, stall);
    chk({tag, "_rdy_drop"}, s_ready, 1'b0);
    wait_end(n + 20);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_crst_run"}, core_reset, 1'b0);
    chk({tag, "_mode_run"}, init_mode, 1'b0);
    chk({tag, "_err"}, err_code, 2'd0);
    chk({tag, "_nwr"}, nwr, n);
    chk({tag, "_sb"}, sb.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_crst", core_reset, 1'b1);
    chk("rst_rdy", s_ready, 1'b0);
    chk("rst_mode", init_mode, 1'b0);
    chk("rst_we", write_enable, 1'b0);
    chk("rst_flags", {busy, done, error, err_code}, 5'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic fixed-program load
    nwr = 0;
    wq.delete();
    wq.push_back(32'h20010005); wq.push_back(32'h20020003); wq.push_back(32'h00221820);
    do_start(3, 32'h20010005 + 32'h20020003 + 32'h00221820);
    chk("basic_busy", busy, 1'b1);
    send(3, 1'b0);
    chk("basic_rdy_drop", s_ready, 1'b0);
    wait_end(20);
    chk("basic_done", done, 1'b1);
    chk("basic_crst", core_reset, 1'b0);
    chk("basic_nwr", nwr, 3);

    // Stalled host, restarted from RUN
    good_load("stall", 4, 1'b1);

    // Bad checksum
    nwr = 0;
    fill(2);
    do_start(2, qsum() + 1);
    send(2, 1'b0);
    wait_end(20);
    chk("sum_err", error, 1'b1);
    chk("sum_code", err_code, 2'd2);
    chk("sum_crst", core_reset, 1'b1);
    chk("sum_done", done, 1'b0);
    chk("sum_nwr", nwr, 2);

    // Bad counts
    nwr = 0;
    do_start(0, '0);
    chk("cnt0_err", error, 1'b1);
    chk("cnt0_code", err_code, 2'd1);
    do_start(4097, '0);
    repeat (3) @(negedge clk);
    chk("cnt4097_err", error, 1'b1);
    chk("cnt4097_code", err_code, 2'd1);
    chk("cnt_nwr", nwr, 0);

    // Abort out of ERROR clears the code
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_err_clr", {error, err_code}, 3'd0);

    // Abort mid-load; the beat offered during abort must be dropped
    nwr = 0;
    fill(5);
    do_start(5, qsum());
    send(2, 1'b0);
    abort = 1'b1; start = 1'b1; word_count = 13'd1; s_valid = 1'b1; s_data = wq[2];
    @(negedge clk);
    abort = 1'b0; start = 1'b0; s_valid = 1'b0;
    chk("abort_rdy", s_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_crst", core_reset, 1'b1);
    chk("abort_we", write_enable, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_nwr", nwr, 2);
    chk("abort_sb", sb.size(), 0);
    good_load("post_abort", 1, 1'b0);

    // Async reset mid-load
    fill(5);
    do_start(5, qsum());
    send(2, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst_crst", core_reset, 1'b1);
    chk("arst_rdy", s_ready, 1'b0);
    chk("arst_mode", init_mode, 1'b0);
    chk("arst_flags", {busy, done, error, write_enable}, 4'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    good_load("post_rst", 3, 1'b0);

    // Full depth
    good_load("full", 4096, 1'b0);
    chk("full_last_addr", last_addr, 12'd4095);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
